// File: rtl/pwr_en_sequencer.sv
// rtl/pwr_en_sequencer.sv - steps a power-enable pattern through settle/measure windows
module pwr_en_sequencer #(
    parameter int NUM_MODULES    = 32,
    parameter int SETTLE_CYCLES  = 10000000,
    parameter int MEASURE_CYCLES = 100000000,
    parameter int STEP_W         = $clog2(NUM_MODULES + 1)
) (
    input  logic                   clk100m,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    input  logic                   loop,
    input  logic [NUM_MODULES-1:0] manual_mask,
    output logic [NUM_MODULES-1:0] pwr_en_out,
    output logic [STEP_W-1:0]      step_idx,
    output logic                   busy,
    output logic                   meas_active,
    output logic                   step_strobe,
    output logic                   done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_DONE
    } state_t;

    localparam logic [1:0]  MODE_RAMP    = 2'd0;
    localparam logic [1:0]  MODE_WALK    = 2'd1;
    localparam logic [1:0]  MODE_MASK    = 2'd2;
    localparam logic [1:0]  MODE_RSVD    = 2'd3;
    localparam logic [31:0] SETTLE_LOAD  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] MEASURE_LOAD = 32'(MEASURE_CYCLES - 1);
    localparam logic [STEP_W-1:0] LAST_MULTI = STEP_W'(NUM_MODULES);

    state_t                 state_q, state_d;
    logic [31:0]            timer_q, timer_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic [NUM_MODULES-1:0] pwr_q, pwr_d;
    logic                   busy_q, busy_d;
    logic                   meas_q, meas_d;
    logic                   strobe_q, strobe_d;
    logic                   done_q, done_d;
    logic [1:0]             mode_q, mode_d;
    logic                   loop_q, loop_d;
    logic [NUM_MODULES-1:0] mask_q, mask_d;
    logic [STEP_W-1:0]      last_step;

    // Step 0 of RAMP and WALK is the all-off baseline; the reserved mode never runs.
    function automatic logic [NUM_MODULES-1:0] pattern(input logic [1:0] m,
                                                        input logic [NUM_MODULES-1:0] msk,
                                                        input logic [STEP_W-1:0] k);
        logic [NUM_MODULES-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            case (m)
                MODE_RAMP: p[i] = (i < int'(k));
                MODE_WALK: p[i] = ((i + 1) == int'(k));
                MODE_MASK: p[i] = msk[i];
                default:   p[i] = 1'b0;
            endcase
        end
        return p;
    endfunction

    assign last_step = (mode_q == MODE_MASK) ? '0 : LAST_MULTI;

    always_ff @(posedge clk100m) begin
        if (rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            step_q   <= '0;
            pwr_q    <= '0;
            busy_q   <= 1'b0;
            meas_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            mode_q   <= '0;
            loop_q   <= 1'b0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            step_q   <= step_d;
            pwr_q    <= pwr_d;
            busy_q   <= busy_d;
            meas_q   <= meas_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            mode_q   <= mode_d;
            loop_q   <= loop_d;
            mask_q   <= mask_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        step_d   = step_q;
        pwr_d    = pwr_q;
        busy_d   = busy_q;
        meas_d   = 1'b0;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        mode_d   = mode_q;
        loop_d   = loop_q;
        mask_d   = mask_q;

        case (state_q)
            S_IDLE: begin
                step_d = '0;
                pwr_d  = '0;
                busy_d = 1'b0;
                if (start && !abort && (mode != MODE_RSVD)) begin
                    mode_d  = mode;
                    loop_d  = loop;
                    mask_d  = manual_mask;
                    state_d = S_SETTLE;
                    timer_d = SETTLE_LOAD;
                    pwr_d   = pattern(mode, manual_mask, '0);
                    busy_d  = 1'b1;
                end
            end
            S_SETTLE: begin
                if (timer_q == '0) begin
                    state_d  = S_MEASURE;
                    timer_d  = MEASURE_LOAD;
                    meas_d   = 1'b1;
                    strobe_d = 1'b1;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_MEASURE: begin
                if (timer_q == '0) begin
                    if (step_q != last_step) begin
                        state_d = S_SETTLE;
                        timer_d = SETTLE_LOAD;
                        step_d  = step_q + STEP_W'(1);
                        pwr_d   = pattern(mode_q, mask_q, step_q + STEP_W'(1));
                    end else if (loop_q) begin
                        state_d = S_SETTLE;
                        timer_d = SETTLE_LOAD;
                        step_d  = '0;
                        pwr_d   = pattern(mode_q, mask_q, '0);
                    end else begin
                        // step_idx keeps the last step through the DONE cycle
                        state_d = S_DONE;
                        pwr_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                    meas_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                step_d  = '0;
                pwr_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
                pwr_d   = '0;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides whatever the active state decided, so done never pulses.
        if ((state_q != S_IDLE) && abort) begin
            state_d  = S_IDLE;
            timer_d  = '0;
            step_d   = '0;
            pwr_d    = '0;
            busy_d   = 1'b0;
            meas_d   = 1'b0;
            strobe_d = 1'b0;
            done_d   = 1'b0;
        end
    end

    assign pwr_en_out  = pwr_q;
    assign step_idx    = step_q;
    assign busy        = busy_q;
    assign meas_active = meas_q;
    assign step_strobe = strobe_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pwr_en_sequencer.sv
// tb/tb_pwr_en_sequencer.sv - directed self-checking bench for pwr_en_sequencer
module tb_pwr_en_sequencer;

    localparam int NM = 4;
    localparam int SC = 2;
    localparam int MC = 3;
    localparam int SW = 3;

    logic          clk100m = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          loop = 1'b0;
    logic [NM-1:0] manual_mask = '0;
    logic [NM-1:0] pwr_en_out;
    logic [SW-1:0] step_idx;
    logic          busy;
    logic          meas_active;
    logic          step_strobe;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [3:0] ramp_pat [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
    logic [3:0] walk_pat [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    pwr_en_sequencer #(
        .NUM_MODULES   (NM),
        .SETTLE_CYCLES (SC),
        .MEASURE_CYCLES(MC),
        .STEP_W        (SW)
    ) dut (
        .clk100m    (clk100m),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .loop       (loop),
        .manual_mask(manual_mask),
        .pwr_en_out (pwr_en_out),
        .step_idx   (step_idx),
        .busy       (busy),
        .meas_active(meas_active),
        .step_strobe(step_strobe),
        .done       (done)
    );

    always #5 clk100m = ~clk100m;

    task automatic tick();
        @(posedge clk100m);
        #1;
    endtask

    // {pwr_en_out, step_idx, busy, meas_active, step_strobe, done}
    function automatic logic [10:0] obs();
        return {pwr_en_out, step_idx, busy, meas_active, step_strobe, done};
    endfunction

    task automatic test_reset();
        logic [10:0] got;
        rst = 1'b1;
        tick();
        tick();
        got = obs();
        checks++;
        if (got !== 11'b0) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", got, 11'b0);
        end
        rst = 1'b0;
        tick();
        got = obs();
        checks++;
        if (got !== 11'b0) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", got, 11'b0);
        end
    endtask

    // Full non-looping run; inputs are scrambled after start to prove they were latched.
    task automatic run_full_sequence(input logic [1:0] m, input int mid_start, input string tag);
        logic [10:0] expv;
        logic [10:0] got;
        logic [3:0]  pat;
        int          s;
        int          ph;
        mode = m;
        loop = 1'b0;
        manual_mask = 4'b0110;
        start = 1'b1;
        tick();
        start = 1'b0;
        loop = 1'b1;
        manual_mask = 4'b1001;
        mode = (m == 2'd0) ? 2'd1 : 2'd0;
        for (int c = 1; c <= 27; c++) begin
            if (c <= 25) begin
                s = (c - 1) / 5;
                ph = (c - 1) % 5;
                pat = (m == 2'd0) ? ramp_pat[s] : walk_pat[s];
                expv = {pat, 3'(s), 1'b1, (ph >= 2), (ph == 2), 1'b0};
            end else if (c == 26) begin
                expv = {4'b0000, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1};
            end else begin
                expv = 11'b0;
            end
            got = obs();
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b expected %b", tag, c, got, expv);
            end
            start = (c == mid_start);
            tick();
        end
        start = 1'b0;
        loop = 1'b0;
        mode = 2'd0;
    endtask

    task automatic test_ramp();
        run_full_sequence(2'd0, -1, "ramp");
    endtask

    task automatic test_walk();
        run_full_sequence(2'd1, -1, "walk");
    endtask

    task automatic test_start_mid_run();
        run_full_sequence(2'd0, 7, "start_mid_run");
    endtask

    task automatic test_mask_loop();
        logic [10:0] expv;
        logic [10:0] got;
        int          ph;
        mode = 2'd2;
        loop = 1'b1;
        manual_mask = 4'b1010;
        start = 1'b1;
        tick();
        start = 1'b0;
        manual_mask = 4'b0101;
        loop = 1'b0;
        mode = 2'd0;
        for (int c = 1; c <= 40; c++) begin
            ph = (c - 1) % 5;
            expv = {4'b1010, 3'd0, 1'b1, (ph >= 2), (ph == 2), 1'b0};
            got = obs();
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL mask_loop cycle %0d: got %b expected %b", c, got, expv);
            end
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        got = obs();
        checks++;
        if (got !== 11'b0) begin
            errors++;
            $display("FAIL mask_loop_abort: got %b expected %b", got, 11'b0);
        end
    endtask

    task automatic test_abort();
        logic [10:0] expv;
        logic [10:0] got;
        int          s;
        int          ph;
        mode = 2'd0;
        loop = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            s = (c - 1) / 5;
            ph = (c - 1) % 5;
            expv = {ramp_pat[s], 3'(s), 1'b1, (ph >= 2), (ph == 2), 1'b0};
            got = obs();
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL abort_pre cycle %0d: got %b expected %b", c, got, expv);
            end
            abort = (c == 12);
            tick();
        end
        abort = 1'b0;
        for (int c = 13; c <= 32; c++) begin
            got = obs();
            checks++;
            if (got !== 11'b0) begin
                errors++;
                $display("FAIL abort_post cycle %0d: got %b expected %b", c, got, 11'b0);
            end
            tick();
        end
    endtask

    task automatic test_ignored_idle();
        logic [10:0] got;
        mode = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            got = obs();
            checks++;
            if (got !== 11'b0) begin
                errors++;
                $display("FAIL mode3_start cycle %0d: got %b expected %b", c, got, 11'b0);
            end
            tick();
        end
        mode = 2'd0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            got = obs();
            checks++;
            if (got !== 11'b0) begin
                errors++;
                $display("FAIL start_abort cycle %0d: got %b expected %b", c, got, 11'b0);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        logic [10:0] expv;
        logic [10:0] got;
        int          s;
        int          ph;
        mode = 2'd0;
        loop = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            s = (c - 1) / 5;
            ph = (c - 1) % 5;
            expv = {ramp_pat[s], 3'(s), 1'b1, (ph >= 2), (ph == 2), 1'b0};
            got = obs();
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL reset_mid_pre cycle %0d: got %b expected %b", c, got, expv);
            end
            rst = (c == 9);
            tick();
        end
        rst = 1'b0;
        got = obs();
        checks++;
        if (got !== 11'b0) begin
            errors++;
            $display("FAIL reset_mid cycle 10: got %b expected %b", got, 11'b0);
        end
        tick();
        run_full_sequence(2'd0, -1, "reset_rerun");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_walk();
        test_mask_loop();
        test_abort();
        test_start_mid_run();
        test_ignored_idle();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
